// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath.
// The data-select mux, the ALU and reg_file all use these defaults and typedefs,
// so the blocks agree on word width and register address width.
// No ports (package).
package cpu_pkg;

    localparam int CPU_DATA_WIDTH = 8;
    localparam int CPU_ADDR_WIDTH = 2;
    localparam int CPU_NUM_REGS   = 1 << CPU_ADDR_WIDTH;

    typedef logic [CPU_DATA_WIDTH-1:0] data_t;
    typedef logic [CPU_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file.
// It selects a stored word and then applies two overrides:
//   - forwarding: a write to the same address in this cycle wins (BYPASS=1);
//   - hard-wired zero: address 0 always reads 0 (ZERO_REG=1). This is applied
//     last, so it also wins over forwarding.
// Ports:
//   rst_n    in  : active-low reset; forwarding is suppressed while it is low
//   wr_en    in  : write enable of the write port
//   wr_addr  in  : write address
//   wr_data  in  : write data
//   addr     in  : read address for this port
//   regs     in  : storage array, one word per register
//   data     out : the selected word after the overrides
module reg_file_rd_port
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] regs [1 << ADDR_WIDTH],
    output logic [DATA_WIDTH-1:0] data
);

    logic fwd_hit;

    // A write that reset will block must not be forwarded either, so the
    // read shows the stored value while rst_n is low.
    assign fwd_hit = (BYPASS != 0) && wr_en && rst_n && (addr == wr_addr);

    always_comb begin
        data = regs[addr];
        if (fwd_hit) begin
            data = wr_data;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// General-purpose register file for the 8-bit CPU datapath.
// One synchronous write port, fed by the data-select mux, and two
// combinational read ports for the ALU operands. A per-register mask records
// which registers were written since the last reset.
// Ports:
//   clk        in  : system clock, all state changes on the rising edge
//   rst_n      in  : synchronous active-low reset; clears storage and mask,
//                    and blocks any write in the same cycle
//   wr_en      in  : write enable
//   wr_addr    in  : destination register
//   wr_data    in  : write data, stored verbatim
//   rd_addr_a  in  : read port A address
//   rd_addr_b  in  : read port B address
//   rd_data_a  out : read port A data (0-cycle latency)
//   rd_data_b  out : read port B data (0-cycle latency)
//   written    out : bit i set once register i has been written since reset
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_a,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_b,
    output logic [DATA_WIDTH-1:0]        rd_data_a,
    output logic [DATA_WIDTH-1:0]        rd_data_b,
    output logic [(1<<ADDR_WIDTH)-1:0]   written
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_fire;

    // With a hard-wired zero register, writes to address 0 are dropped
    // entirely, so neither the storage nor the written mask changes.
    assign wr_fire = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            written <= '0;
        end else if (wr_fire) begin
            regs[wr_addr]    <= wr_data;
            written[wr_addr] <= 1'b1;
        end
    end

    reg_file_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS),
        .ZERO_REG   (ZERO_REG)
    ) u_port_a (
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .addr    (rd_addr_a),
        .regs    (regs),
        .data    (rd_data_a)
    );

    reg_file_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS),
        .ZERO_REG   (ZERO_REG)
    ) u_port_b (
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .addr    (rd_addr_b),
        .regs    (regs),
        .data    (rd_data_b)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file. Three instances share one stimulus stream:
//   dut    : BYPASS=1, ZERO_REG=0
//   dut_nb : BYPASS=0, ZERO_REG=0
//   dut_z  : BYPASS=1, ZERO_REG=1
// Expected contents come from a small reference array kept by the bench.
module tb_reg_file;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr_a;
    logic [1:0] rd_addr_b;

    logic [7:0] rd_a, rd_b, rd_a_nb, rd_b_nb, rd_a_z, rd_b_z;
    logic [3:0] wmask, wmask_nb, wmask_z;

    int vectors;
    int miscompares;

    // reference model
    logic [7:0] exp_mem [4];
    logic [3:0] exp_written;
    logic [7:0] exp_q [$];

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_file #(.BYPASS(1), .ZERO_REG(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_a), .rd_data_b(rd_b), .written(wmask)
    );

    reg_file #(.BYPASS(0), .ZERO_REG(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_a_nb), .rd_data_b(rd_b_nb), .written(wmask_nb)
    );

    reg_file #(.BYPASS(1), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_a_z), .rd_data_b(rd_b_z), .written(wmask_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, land 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one write cycle, model updated to match
    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        exp_mem[a]     = d;
        exp_written[a] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_mem[i] = 8'h00;
        exp_written = 4'b0000;
    endtask

    // read every register through both ports on all instances (wr_en=0)
    task automatic check_all(input string tag);
        logic [1:0] ra, rb;
        for (int i = 0; i < 4; i++) begin
            ra = 2'(i);
            rb = 2'(i + 1);
            rd_addr_a = ra;
            rd_addr_b = rb;
            #1;
            check({tag, "_a"},    rd_a,    exp_mem[ra]);
            check({tag, "_b"},    rd_b,    exp_mem[rb]);
            check({tag, "_nb_a"}, rd_a_nb, exp_mem[ra]);
            check({tag, "_nb_b"}, rd_b_nb, exp_mem[rb]);
            check({tag, "_z_a"},  rd_a_z,  (ra == 2'd0) ? 8'h00 : exp_mem[ra]);
            check({tag, "_z_b"},  rd_b_z,  (rb == 2'd0) ? 8'h00 : exp_mem[rb]);
        end
        check({tag, "_written"},    wmask,    exp_written);
        check({tag, "_written_nb"}, wmask_nb, exp_written);
        check({tag, "_written_z"},  wmask_z,  exp_written & 4'b1110);
    endtask

    initial begin
        logic [7:0] d0, d1, mux_out, exp_v;
        logic       sel;

        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 2'd0;
        wr_data   = 8'h00;
        rd_addr_a = 2'd0;
        rd_addr_b = 2'd0;
        model_reset();

        // initial reset
        tick();
        tick();
        rst_n = 1'b1;
        check_all("reset_init");

        // preload reg1, then reset with a competing write
        write_reg(2'd1, 8'hAA);
        check_all("preload");
        rst_n     = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 2'd1;
        wr_data   = 8'h55;
        rd_addr_a = 2'd1;
        rd_addr_b = 2'd1;
        #1;
        check("rst_no_fwd_a",    rd_a,    8'hAA);
        check("rst_no_fwd_b",    rd_b,    8'hAA);
        check("rst_no_fwd_z_a",  rd_a_z,  8'hAA);
        tick();
        wr_en = 1'b0;
        rst_n = 1'b1;
        model_reset();
        check_all("reset_mid");

        // basic write/read
        write_reg(2'd2, 8'h3C);
        write_reg(2'd3, 8'hC3);
        rd_addr_a = 2'd2;
        rd_addr_b = 2'd3;
        #1;
        check("basic_a", rd_a, 8'h3C);
        check("basic_b", rd_b, 8'hC3);
        check("basic_written", wmask, 4'b1100);
        check_all("basic");

        // bypass vs no bypass
        write_reg(2'd1, 8'h10);
        wr_en     = 1'b1;
        wr_addr   = 2'd1;
        wr_data   = 8'hF0;
        rd_addr_a = 2'd1;
        rd_addr_b = 2'd1;
        #1;
        check("byp_pre_a",    rd_a,    8'hF0);
        check("byp_pre_b",    rd_b,    8'hF0);
        check("nobyp_pre_a",  rd_a_nb, 8'h10);
        check("nobyp_pre_b",  rd_b_nb, 8'h10);
        check("byp_pre_z_a",  rd_a_z,  8'hF0);
        // fetched from another address: no forwarding there
        rd_addr_b = 2'd2;
        #1;
        check("byp_other_b",  rd_b,    8'h3C);
        rd_addr_b = 2'd1;
        tick();
        wr_en = 1'b0;
        exp_mem[1] = 8'hF0;
        exp_written[1] = 1'b1;
        #1;
        check("byp_post_a",   rd_a,    8'hF0);
        check("nobyp_post_a", rd_a_nb, 8'hF0);
        check("nobyp_post_b", rd_b_nb, 8'hF0);

        // zero register
        wr_en     = 1'b1;
        wr_addr   = 2'd0;
        wr_data   = 8'hFF;
        rd_addr_a = 2'd0;
        rd_addr_b = 2'd0;
        #1;
        check("zero_pre_z_a", rd_a_z,  8'h00);
        check("zero_pre_z_b", rd_b_z,  8'h00);
        check("zero_pre_a",   rd_a,    8'hFF);
        check("zero_pre_nb",  rd_a_nb, 8'h00);
        tick();
        wr_en = 1'b0;
        exp_mem[0] = 8'hFF;
        exp_written[0] = 1'b1;
        #1;
        check("zero_post_z_a",   rd_a_z,     8'h00);
        check("zero_post_z_w0",  wmask_z[0], 1'b0);
        check("zero_post_a",     rd_a,       8'hFF);
        check("zero_post_nb_a",  rd_a_nb,    8'hFF);
        check("zero_post_w0",    wmask[0],   1'b1);
        check_all("zero");

        // exhaustive sweep: every address, every data value
        for (int a = 0; a < 4; a++) begin
            for (int d = 0; d < 256; d++) begin
                write_reg(2'(a), 8'(d));
                check_all("sweep");
            end
        end

        // mux feeding the write port: select 0 then 1 into reg1
        d0 = 8'h12;
        d1 = 8'h34;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        for (int s = 0; s < 2; s++) begin
            sel     = (s != 0);
            mux_out = sel ? d1 : d0;
            write_reg(2'd1, mux_out);
            rd_addr_a = 2'd1;
            rd_addr_b = 2'd1;
            #1;
            exp_v = exp_q.pop_front();
            check("mux_a", rd_a, exp_v);
            check("mux_b", rd_b, exp_v);
        end

        // a random write with wr_en low must not change state
        wr_en   = 1'b0;
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = 8'($urandom_range(0, 255));
        tick();
        check_all("wr_en_low");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
